// File: rtl/melody_sequencer_pkg.sv
// Shared definitions for the melody sequencer and the buzzer stage:
// note codes, tune IDs, ROM entry layout and sequencer state encoding.
package melody_sequencer_pkg;

  localparam int NOTE_W  = 4;
  localparam int LEN_W   = 4;
  localparam int ENTRY_W = NOTE_W + LEN_W;
  localparam int IDX_W   = 3;
  localparam int TUNE_W  = 2;

  localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
  localparam logic [NOTE_W-1:0] NOTE_C6   = 4'd1;
  localparam logic [NOTE_W-1:0] NOTE_D6   = 4'd2;
  localparam logic [NOTE_W-1:0] NOTE_E6   = 4'd3;
  localparam logic [NOTE_W-1:0] NOTE_F6   = 4'd4;
  localparam logic [NOTE_W-1:0] NOTE_G6   = 4'd5;
  localparam logic [NOTE_W-1:0] NOTE_B6   = 4'd6;
  localparam logic [NOTE_W-1:0] NOTE_C7   = 4'd7;
  localparam logic [NOTE_W-1:0] NOTE_G5   = 4'd8;
  localparam logic [NOTE_W-1:0] NOTE_F4   = 4'd9;
  localparam logic [NOTE_W-1:0] NOTE_B3   = 4'd10;

  localparam logic [TUNE_W-1:0] TUNE_DROP    = 2'd0;
  localparam logic [TUNE_W-1:0] TUNE_WIN     = 2'd1;
  localparam logic [TUNE_W-1:0] TUNE_LOSE    = 2'd2;
  localparam logic [TUNE_W-1:0] TUNE_INVALID = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // ROM entries are {note, len}; len == 0 marks the end of a tune.
  function automatic logic [ENTRY_W-1:0] rom_entry(input logic [NOTE_W-1:0] n,
                                                   input logic [LEN_W-1:0]  len);
    return {n, len};
  endfunction

endpackage

// File: rtl/melody_sequencer_tune_rom.sv
// Combinational tune table: (tune, idx) -> {note, len}.
// Any address past a tune's listed notes reads as the end marker.
module melody_sequencer_tune_rom
  import melody_sequencer_pkg::*;
(
  input  logic [TUNE_W-1:0]  i_tune,
  input  logic [IDX_W-1:0]   i_idx,
  output logic [ENTRY_W-1:0] o_entry
);

  always_comb begin
    o_entry = '0;
    case (i_tune)
      TUNE_DROP: begin
        case (i_idx)
          3'd0:    o_entry = rom_entry(NOTE_G5, 4'd4);
          3'd1:    o_entry = rom_entry(NOTE_C6, 4'd4);
          default: o_entry = '0;
        endcase
      end
      TUNE_WIN: begin
        case (i_idx)
          3'd0:    o_entry = rom_entry(NOTE_C6, 4'd8);
          3'd1:    o_entry = rom_entry(NOTE_E6, 4'd8);
          3'd2:    o_entry = rom_entry(NOTE_G6, 4'd8);
          3'd3:    o_entry = rom_entry(NOTE_C7, 4'd15);
          default: o_entry = '0;
        endcase
      end
      TUNE_LOSE: begin
        case (i_idx)
          3'd0:    o_entry = rom_entry(NOTE_G5, 4'd10);
          3'd1:    o_entry = rom_entry(NOTE_F4, 4'd10);
          3'd2:    o_entry = rom_entry(NOTE_B3, 4'd15);
          default: o_entry = '0;
        endcase
      end
      default: begin
        case (i_idx)
          3'd0:    o_entry = rom_entry(NOTE_B3, 4'd6);
          3'd1:    o_entry = rom_entry(NOTE_REST, 4'd3);
          3'd2:    o_entry = rom_entry(NOTE_B3, 4'd6);
          default: o_entry = '0;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/melody_sequencer.sv
// Plays a ROM tune to the buzzer: note/enable per entry for len ticks, silent gaps,
// done pulse at the end marker. Define MELODY_PREEMPT_EN to let start abort a running tune.
module melody_sequencer
  import melody_sequencer_pkg::*;
#(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int TICK_HZ   = 100,
  parameter int GAP_TICKS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [TUNE_W-1:0] tune_sel,
  output logic [NOTE_W-1:0] note,
  output logic              enable,
  output logic              busy,
  output logic              done,
  output logic [1:0]        o_dbg_state
);

  localparam int                DIV      = CLK_FREQ / TICK_HZ;
  localparam int                PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [LEN_W-1:0]  GAP_LEN  = LEN_W'(GAP_TICKS);
  localparam logic [IDX_W-1:0]  IDX_LAST = '1;

  state_t              r_state, w_state_nxt;
  logic [TUNE_W-1:0]   r_tune, w_tune_nxt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic [PRE_W-1:0]    r_pre, w_pre_nxt;
  logic [LEN_W-1:0]    r_ticks, w_ticks_nxt;
  logic [LEN_W-1:0]    r_len, w_len_nxt;
  logic [NOTE_W-1:0]   r_note, w_note_nxt;
  logic                r_enable, w_enable_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;

  logic                w_accept;
  logic                w_tick;
  logic                w_fetch;
  logic [TUNE_W-1:0]   w_rom_tune;
  logic [IDX_W-1:0]    w_rom_idx;
  logic [ENTRY_W-1:0]  w_entry;
  logic [NOTE_W-1:0]   w_entry_note;
  logic [LEN_W-1:0]    w_entry_len;

`ifdef MELODY_PREEMPT_EN
  assign w_accept = start;
`else
  assign w_accept = start && (r_state == ST_IDLE);
`endif

  // The ROM is addressed with entry 0 of the requested tune on acceptance,
  // otherwise with the entry following the current one.
  assign w_tick       = (r_pre == PRE_LAST);
  assign w_rom_tune   = w_accept ? tune_sel : r_tune;
  assign w_rom_idx    = w_accept ? '0 : ((r_idx == IDX_LAST) ? r_idx : r_idx + 1'b1);
  assign w_entry_note = w_entry[ENTRY_W-1 -: NOTE_W];
  assign w_entry_len  = w_entry[LEN_W-1:0];

  melody_sequencer_tune_rom u_rom (
    .i_tune  (w_rom_tune),
    .i_idx   (w_rom_idx),
    .o_entry (w_entry)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_tune_nxt   = r_tune;
    w_idx_nxt    = r_idx;
    w_pre_nxt    = r_pre;
    w_ticks_nxt  = r_ticks;
    w_len_nxt    = r_len;
    w_note_nxt   = r_note;
    w_enable_nxt = r_enable;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_fetch      = 1'b0;

    case (r_state)
      ST_PLAY: begin
        if (w_tick) begin
          w_pre_nxt = '0;
          if (r_ticks + 4'd1 == r_len) begin
            w_ticks_nxt = '0;
            if (GAP_LEN == 4'd0) begin
              w_fetch = 1'b1;
            end else begin
              w_state_nxt  = ST_GAP;
              w_enable_nxt = 1'b0;
            end
          end else begin
            w_ticks_nxt = r_ticks + 4'd1;
          end
        end else begin
          w_pre_nxt = r_pre + 1'b1;
        end
      end
      ST_GAP: begin
        if (w_tick) begin
          w_pre_nxt = '0;
          if (r_ticks + 4'd1 == GAP_LEN) begin
            w_ticks_nxt = '0;
            w_fetch     = 1'b1;
          end else begin
            w_ticks_nxt = r_ticks + 4'd1;
          end
        end else begin
          w_pre_nxt = r_pre + 1'b1;
        end
      end
      default: ;
    endcase

    if (w_fetch) begin
      w_pre_nxt   = '0;
      w_ticks_nxt = '0;
      if (w_entry_len == 4'd0) begin
        w_state_nxt  = ST_IDLE;
        w_idx_nxt    = '0;
        w_note_nxt   = NOTE_REST;
        w_enable_nxt = 1'b0;
        w_busy_nxt   = 1'b0;
        w_done_nxt   = 1'b1;
      end else begin
        w_state_nxt  = ST_PLAY;
        w_idx_nxt    = w_rom_idx;
        w_len_nxt    = w_entry_len;
        w_note_nxt   = w_entry_note;
        w_enable_nxt = (w_entry_note != NOTE_REST);
      end
    end

    // Acceptance overrides any fetch, which also drops the aborted tune's done pulse.
    if (w_accept) begin
      w_state_nxt  = ST_PLAY;
      w_tune_nxt   = tune_sel;
      w_idx_nxt    = '0;
      w_pre_nxt    = '0;
      w_ticks_nxt  = '0;
      w_len_nxt    = w_entry_len;
      w_note_nxt   = w_entry_note;
      w_enable_nxt = (w_entry_note != NOTE_REST);
      w_busy_nxt   = 1'b1;
      w_done_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_tune   <= '0;
      r_idx    <= '0;
      r_pre    <= '0;
      r_ticks  <= '0;
      r_len    <= '0;
      r_note   <= NOTE_REST;
      r_enable <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_tune   <= w_tune_nxt;
      r_idx    <= w_idx_nxt;
      r_pre    <= w_pre_nxt;
      r_ticks  <= w_ticks_nxt;
      r_len    <= w_len_nxt;
      r_note   <= w_note_nxt;
      r_enable <= w_enable_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign note        = r_note;
  assign enable      = r_enable;
  assign busy        = r_busy;
  assign done        = r_done;
  assign o_dbg_state = r_state;

endmodule
